// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared types and defaults for the TFT SPI arbiter
//
// Holds the arbiter state encoding and the default requester count and
// idle-owner timeout used by tft_spi_arbiter.
package tft_pkg;

  localparam int TFT_N_REQ   = 3;
  localparam int TFT_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/tft_spi_arbiter_rr_pick.sv
// rtl/tft_spi_arbiter_rr_pick.sv - combinational round-robin one-hot selector
//
// Ports:
//   i_mask  candidate requesters
//   i_ptr   index of the highest-priority candidate this round
//   o_win   one-hot winner (all zero when i_mask is empty)
//   o_any   at least one candidate present
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic          o_any
);

  logic w_found;

  always_comb begin
    o_win   = '0;
    w_found = 1'b0;
    // First pass scans from the pointer upward, second pass wraps to index 0.
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_mask[j] && (j >= int'(i_ptr))) begin
        o_win[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_mask[j]) begin
        o_win[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/tft_spi_arbiter.sv
// rtl/tft_spi_arbiter.sv - ownership arbiter sharing one SPI transmitter between TFT requesters
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester ownership request (held for a whole burst)
//   data_in, dc_in  per-requester byte and data/command flag (byte i at [8i+7:8i])
//   transmit_in     per-requester byte-start strobe
//   gnt             one-hot registered ownership grant
//   busy_out        spi_busy to the owner, 1 to everybody else
//   spi_data, spi_dc, spi_transmit  muxed towards the SPI transmitter
//   spi_busy        SPI transmitter busy
//   init_done       sticky, set when requester 0 releases its first grant
//   timeout_err     one-cycle pulse on a forced release
module tft_spi_arbiter
  import tft_pkg::*;
#(
  parameter int N_REQ   = TFT_N_REQ,
  parameter int TIMEOUT = TFT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data_in,
  input  logic [N_REQ-1:0]   dc_in,
  input  logic [N_REQ-1:0]   transmit_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   busy_out,
  output logic [7:0]         spi_data,
  output logic               spi_dc,
  output logic               spi_transmit,
  input  logic               spi_busy,
  output logic               init_done,
  output logic               timeout_err
);

  localparam int               PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] REQ0_BIT = N_REQ'(1);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

  arb_state_t       r_state, w_state_next;
  logic [N_REQ-1:0] r_gnt, w_gnt_next;
  logic [N_REQ-1:0] r_ignore, w_ignore_next;
  logic [PW-1:0]    r_ptr, w_ptr_next;
  logic [15:0]      r_cnt, w_cnt_next;
  logic             r_init_done, w_init_next;
  logic             r_timeout_err, w_tmo_next;

  logic [N_REQ-1:0] w_qual, w_rr_mask, w_rr_win;
  logic             w_rr_any;
  logic [PW-1:0]    w_rr_idx, w_own_idx;
  logic             w_own_req, w_own_tx, w_own_exit;

  // Before init completes only the display-init requester may win; requesters
  // that timed out stay masked until they drop req.
  always_comb begin
    w_qual = req & ~r_ignore;
    if (!r_init_done) begin
      w_qual = w_qual & REQ0_BIT;
    end
  end

  assign w_rr_mask = w_qual & ~REQ0_BIT;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .i_mask (w_rr_mask),
    .i_ptr  (r_ptr),
    .o_win  (w_rr_win),
    .o_any  (w_rr_any)
  );

  always_comb begin
    w_rr_idx  = '0;
    w_own_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_rr_win[j]) w_rr_idx = PW'(j);
      if (r_gnt[j])    w_own_idx = PW'(j);
    end
  end

  assign w_own_req = |(req & r_gnt);
  assign w_own_tx  = |(transmit_in & r_gnt);

  always_comb begin
    w_state_next  = r_state;
    w_gnt_next    = r_gnt;
    w_ptr_next    = r_ptr;
    w_cnt_next    = '0;
    w_ignore_next = r_ignore & req;
    w_init_next   = r_init_done;
    w_tmo_next    = 1'b0;
    w_own_exit    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!spi_busy) begin
          if (w_qual[0]) begin
            w_state_next = ST_OWN;
            w_gnt_next   = REQ0_BIT;
          end else if (w_rr_any) begin
            w_state_next = ST_OWN;
            w_gnt_next   = w_rr_win;
          end
        end
      end

      ST_OWN: begin
        if (!(w_own_tx || spi_busy)) begin
          w_cnt_next = r_cnt + 16'd1;
        end
        if (!w_own_req) begin
          w_own_exit = 1'b1;
        end else if (!(w_own_tx || spi_busy) && (r_cnt == TMO_LAST)) begin
          w_own_exit    = 1'b1;
          w_tmo_next    = 1'b1;
          w_ignore_next = (r_ignore & req) | r_gnt;
        end
        if (w_own_exit) begin
          w_state_next = ST_DRAIN;
          w_gnt_next   = '0;
          if (r_gnt[0]) begin
            w_init_next = 1'b1;
          end else begin
            w_ptr_next = (w_own_idx == PW'(N_REQ - 1)) ? PW'(1) : w_own_idx + PW'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (!spi_busy) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_ignore      <= '0;
      r_ptr         <= PW'(1);
      r_cnt         <= '0;
      r_init_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_gnt         <= w_gnt_next;
      r_ignore      <= w_ignore_next;
      r_ptr         <= w_ptr_next;
      r_cnt         <= w_cnt_next;
      r_init_done   <= w_init_next;
      r_timeout_err <= w_tmo_next;
    end
  end

  // r_gnt is non-zero only in OWN, so selecting on it also forces the SPI
  // side to zero in IDLE/DRAIN and immediately on reset.
  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    busy_out     = '1;
    for (int j = 0; j < N_REQ; j++) begin
      if (r_gnt[j]) begin
        spi_data     = data_in[8*j +: 8];
        spi_dc       = dc_in[j];
        spi_transmit = transmit_in[j];
        busy_out[j]  = spi_busy;
      end
    end
  end

  assign gnt         = r_gnt;
  assign init_done   = r_init_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tft_spi_arbiter.sv
// tb/tb_tft_spi_arbiter.sv - directed vector bench for tft_spi_arbiter
module tb_tft_spi_arbiter;

  localparam logic [23:0] D0 = 24'hC2B1A0;
  localparam logic [23:0] D1 = 24'hA55AA0;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, dc_in, transmit_in;
  logic [23:0] data_in;
  logic        spi_busy;
  logic [2:0]  gnt, busy_out;
  logic [7:0]  spi_data;
  logic        spi_dc, spi_transmit, init_done, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tft_spi_arbiter #(
    .N_REQ   (3),
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .data_in      (data_in),
    .dc_in        (dc_in),
    .transmit_in  (transmit_in),
    .gnt          (gnt),
    .busy_out     (busy_out),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_transmit (spi_transmit),
    .spi_busy     (spi_busy),
    .init_done    (init_done),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  tx;
    logic [2:0]  dc;
    logic [23:0] data;
    logic [2:0]  e_gnt;
    logic        e_tx;
    logic [7:0]  e_data;
    logic        e_dc;
    logic [2:0]  e_busy;
    logic        e_init;
  } vec_t;

  vec_t v[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //      req     tx      dc      data  gnt     tx    data   dc    busy    init
    v[0]  = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0};
    v[1]  = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0};
    v[2]  = '{3'b111, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b0};
    v[3]  = '{3'b111, 3'b001, 3'b000, D0, 3'b001, 1'b1, 8'hA0, 1'b0, 3'b110, 1'b0};
    v[4]  = '{3'b110, 3'b000, 3'b000, D0, 3'b001, 1'b0, 8'hA0, 1'b0, 3'b110, 1'b0};
    v[5]  = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[6]  = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[7]  = '{3'b110, 3'b010, 3'b000, D0, 3'b010, 1'b1, 8'hB1, 1'b0, 3'b101, 1'b1};
    v[8]  = '{3'b100, 3'b000, 3'b000, D0, 3'b010, 1'b0, 8'hB1, 1'b0, 3'b101, 1'b1};
    v[9]  = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[10] = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[11] = '{3'b110, 3'b110, 3'b100, D1, 3'b100, 1'b1, 8'hA5, 1'b1, 3'b011, 1'b1};
    v[12] = '{3'b010, 3'b100, 3'b000, D0, 3'b100, 1'b1, 8'hC2, 1'b0, 3'b011, 1'b1};
    v[13] = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[14] = '{3'b110, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[15] = '{3'b111, 3'b000, 3'b000, D0, 3'b010, 1'b0, 8'hB1, 1'b0, 3'b101, 1'b1};
    v[16] = '{3'b101, 3'b000, 3'b000, D0, 3'b010, 1'b0, 8'hB1, 1'b0, 3'b101, 1'b1};
    v[17] = '{3'b111, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[18] = '{3'b111, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[19] = '{3'b110, 3'b000, 3'b000, D0, 3'b001, 1'b0, 8'hA0, 1'b0, 3'b110, 1'b1};
    v[20] = '{3'b000, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};
    v[21] = '{3'b000, 3'b000, 3'b000, D0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b111, 1'b1};

    rst         = 1'b1;
    req         = '0;
    dc_in       = '0;
    transmit_in = '0;
    data_in     = D0;
    spi_busy    = 1'b0;

    @(negedge clk);
    chk("reset gnt", gnt, 3'b000);
    chk("reset busy_out", busy_out, 3'b111);
    chk("reset init_done", init_done, 1'b0);
    chk("reset timeout_err", timeout_err, 1'b0);
    chk("reset spi_transmit", spi_transmit, 1'b0);
    chk("reset spi_data", spi_data, 8'h00);

    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      next_cycle();
      req         = v[i].req;
      transmit_in = v[i].tx;
      dc_in       = v[i].dc;
      data_in     = v[i].data;
      @(negedge clk);
      chk($sformatf("row%0d gnt", i), gnt, v[i].e_gnt);
      chk($sformatf("row%0d spi_transmit", i), spi_transmit, v[i].e_tx);
      chk($sformatf("row%0d spi_data", i), spi_data, v[i].e_data);
      chk($sformatf("row%0d spi_dc", i), spi_dc, v[i].e_dc);
      chk($sformatf("row%0d busy_out", i), busy_out, v[i].e_busy);
      chk($sformatf("row%0d init_done", i), init_done, v[i].e_init);
      chk($sformatf("row%0d timeout_err", i), timeout_err, 1'b0);
    end

    // Drain held open by a busy SPI: owner 1 releases while busy, requester 2 waits.
    next_cycle();
    req = 3'b010;
    @(negedge clk);
    chk("drain pre-grant gnt", gnt, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("drain owner1 gnt", gnt, 3'b010);
    next_cycle();
    req      = 3'b000;
    spi_busy = 1'b1;
    @(negedge clk);
    chk("drain release cycle gnt", gnt, 3'b010);
    chk("drain release busy_out", busy_out, 3'b111);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      req = 3'b100;
      @(negedge clk);
      chk($sformatf("drain busy%0d gnt", i), gnt, 3'b000);
    end
    next_cycle();
    spi_busy = 1'b0;
    @(negedge clk);
    chk("drain first idle-bus gnt", gnt, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("drain idle state gnt", gnt, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("drain regrant gnt", gnt, 3'b100);

    // Owner 2 holds req without transmitting: forced release after 16 owner cycles.
    for (int k = 2; k <= 16; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("tmo own%0d gnt", k), gnt, 3'b100);
      chk($sformatf("tmo own%0d timeout_err", k), timeout_err, 1'b0);
    end
    next_cycle();
    @(negedge clk);
    chk("tmo release gnt", gnt, 3'b000);
    chk("tmo pulse", timeout_err, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("tmo pulse end", timeout_err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("tmo ignored%0d gnt", i), gnt, 3'b000);
    end
    next_cycle();
    req = 3'b000;
    @(negedge clk);
    chk("tmo dropped gnt", gnt, 3'b000);
    next_cycle();
    req = 3'b100;
    @(negedge clk);
    chk("tmo reraise gnt", gnt, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("tmo regrant gnt", gnt, 3'b100);

    // Asynchronous reset in the middle of an owner strobe.
    next_cycle();
    transmit_in = 3'b100;
    @(negedge clk);
    chk("rst pre spi_transmit", spi_transmit, 1'b1);
    chk("rst pre spi_data", spi_data, 8'hC2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async spi_transmit", spi_transmit, 1'b0);
    chk("rst async gnt", gnt, 3'b000);
    chk("rst async spi_data", spi_data, 8'h00);
    chk("rst async busy_out", busy_out, 3'b111);
    chk("rst async init_done", init_done, 1'b0);
    next_cycle();
    rst         = 1'b0;
    transmit_in = 3'b000;
    req         = 3'b110;
    @(negedge clk);
    chk("rst after init-pending gnt", gnt, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("rst after init-pending gnt2", gnt, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
